// File: rtl/text_buffer.sv
// -----------------------------------------------------------------------------
// text_buffer
//
// Character cell buffer for a VGA text window. Bytes from a keyboard/UART
// receiver are written at a cursor; the video side reads the cell under the
// current pixel position with one cycle of latency.
//
// Optional feature (compile-time macro):
//   TEXT_SCROLL_EN  -- when defined, a line feed past the last row scrolls the
//                      window up one row. When undefined, the cursor wraps to
//                      (0,0) and row 0 is cleared instead.
//
// Ports:
//   clk         sole clock, rising edge
//   reset_n     synchronous active-low reset
//   in_data     character/control byte (bit7=1 selects Thai glyph set)
//   in_valid    in_data valid
//   in_ready    byte accepted this cycle when in_valid && in_ready
//   x, y        pixel position from the sync generator
//   ascii_code  registered code of the cell under (x,y), 8'h20 outside window
//   cursor_col  current write column
//   cursor_row  current write row
// -----------------------------------------------------------------------------
module text_buffer #(
    parameter int unsigned X0   = 192,
    parameter int unsigned Y0   = 208,
    parameter int unsigned COLS = 32,
    parameter int unsigned ROWS = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic [7:0] ascii_code,
    output logic [4:0] cursor_col,
    output logic [1:0] cursor_row
);

    localparam int unsigned Cells = COLS * ROWS;
    localparam int unsigned Iw    = (Cells > 1) ? $clog2(Cells) : 1;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StClear  = 2'd1;
`ifdef TEXT_SCROLL_EN
    localparam logic [1:0] StScroll = 2'd2;
    // Cells below this index are refilled from the row beneath during a scroll.
    localparam int unsigned KeepCells = (ROWS - 1) * COLS;
`endif

    logic [7:0]    mem_q [Cells];

    logic [1:0]    state_q, state_d;
    logic [Iw-1:0] idx_q, idx_d;     // CLEAR/SCROLL cell pointer
    logic [Iw-1:0] last_q, last_d;   // final cell of the current CLEAR run
    logic [4:0]    col_q, col_d;
    logic [1:0]    row_q, row_d;
    logic [7:0]    ascii_q, ascii_d;

    logic          mem_we;
    logic [Iw-1:0] mem_wa;
    logic [7:0]    mem_wd;

    logic [Iw-1:0] cur_idx;
    logic          adv;

    // ---------------------------------------------------------------- read path
    logic [31:0]   xw, yw, rd_col, rd_row;
    logic          in_win;
    logic [Iw-1:0] rd_idx;

    always_comb begin
        xw     = 32'(x);
        yw     = 32'(y);
        in_win = (xw >= X0) && (xw < X0 + 8 * COLS) && (yw >= Y0) && (yw < Y0 + 16 * ROWS);
        rd_col = (xw - X0) >> 3;
        rd_row = (yw - Y0) >> 4;
        rd_idx = Iw'(rd_row * COLS + rd_col);
        // Array holds pre-write contents here, so a same-cycle write returns old data.
        ascii_d = in_win ? mem_q[rd_idx] : 8'h20;
    end

`ifdef TEXT_SCROLL_EN
    logic [Iw-1:0] src_idx;
    always_comb begin
        src_idx = Iw'(32'(idx_q) + COLS);
    end
`endif

    // ---------------------------------------------------------------- control
    always_comb begin
        cur_idx = Iw'(32'(row_q) * COLS + 32'(col_q));
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        col_d   = col_q;
        row_d   = row_q;
        mem_we  = 1'b0;
        mem_wa  = idx_q;
        mem_wd  = 8'h20;
        adv     = 1'b0;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (in_data >= 8'h20 && in_data != 8'h7F) begin
                        mem_we = 1'b1;
                        mem_wa = cur_idx;
                        mem_wd = in_data;
                        if (col_q == 5'(COLS - 1)) begin
                            col_d = '0;
                            adv   = 1'b1;
                        end else begin
                            col_d = col_q + 5'd1;
                        end
                    end else if (in_data == 8'h0D) begin
                        col_d = '0;
                        adv   = 1'b1;
                    end else if (in_data == 8'h08) begin
                        // Both backspace cases erase the linear cell before the cursor.
                        if (col_q != '0) begin
                            col_d  = col_q - 5'd1;
                            mem_we = 1'b1;
                            mem_wa = cur_idx - Iw'(1);
                        end else if (row_q != '0) begin
                            row_d  = row_q - 2'd1;
                            col_d  = 5'(COLS - 1);
                            mem_we = 1'b1;
                            mem_wa = cur_idx - Iw'(1);
                        end
                    end else if (in_data == 8'h0C) begin
                        state_d = StClear;
                        idx_d   = '0;
                        last_d  = Iw'(Cells - 1);
                        col_d   = '0;
                        row_d   = '0;
                    end

                    if (adv) begin
                        if (row_q != 2'(ROWS - 1)) begin
                            row_d = row_q + 2'd1;
                        end else begin
`ifdef TEXT_SCROLL_EN
                            state_d = StScroll;
                            idx_d   = '0;
                            row_d   = 2'(ROWS - 1);
`else
                            state_d = StClear;
                            idx_d   = '0;
                            last_d  = Iw'(COLS - 1);
                            row_d   = '0;
`endif
                            col_d   = '0;
                        end
                    end
                end
            end

            StClear: begin
                mem_we = 1'b1;
                mem_wa = idx_q;
                mem_wd = 8'h20;
                if (idx_q == last_q) begin
                    state_d = StIdle;
                end else begin
                    idx_d = idx_q + Iw'(1);
                end
            end

`ifdef TEXT_SCROLL_EN
            StScroll: begin
                // Copy phase then blank phase in a single linear sweep.
                mem_we = 1'b1;
                mem_wa = idx_q;
                mem_wd = (32'(idx_q) < KeepCells) ? mem_q[src_idx] : 8'h20;
                if (idx_q == Iw'(Cells - 1)) begin
                    state_d = StIdle;
                end else begin
                    idx_d = idx_q + Iw'(1);
                end
            end
`endif

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StClear;
            idx_q   <= '0;
            last_q  <= Iw'(Cells - 1);
            col_q   <= '0;
            row_q   <= '0;
            ascii_q <= 8'h20;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            col_q   <= col_d;
            row_q   <= row_d;
            ascii_q <= ascii_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    assign in_ready   = reset_n && (state_q == StIdle);
    assign ascii_code = ascii_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;

endmodule

// File: tb/tb_text_buffer.sv
// -----------------------------------------------------------------------------
// tb_text_buffer
//
// Directed self-checking bench for text_buffer at default parameters.
// Honours TEXT_SCROLL_EN for the last-row line-feed expectations.
// -----------------------------------------------------------------------------
module tb_text_buffer;

    localparam int X0   = 192;
    localparam int Y0   = 208;
    localparam int COLS = 32;
    localparam int ROWS = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] x = 10'd0;
    logic [9:0] y = 10'd0;
    logic [7:0] ascii_code;
    logic [4:0] cursor_col;
    logic [1:0] cursor_row;

    int checks = 0;
    int errors = 0;

    text_buffer #(
        .X0  (X0),
        .Y0  (Y0),
        .COLS(COLS),
        .ROWS(ROWS)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .ascii_code(ascii_code),
        .cursor_col(cursor_col),
        .cursor_row(cursor_row)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // All helpers start and end 1 time unit after a rising edge.
    task automatic wait_ready(output int n);
        n = 0;
        while (!in_ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        wait_ready(n);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%0b required 1 for byte %h", in_ready, b);
        end
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic read_xy(input int px, input int py, output logic [7:0] v);
        x = 10'(px);
        y = 10'(py);
        @(posedge clk);
        #1;
        v = ascii_code;
    endtask

    task automatic read_cell(input int r, input int c, output logic [7:0] v);
        read_xy(X0 + 8 * c + (c % 8), Y0 + 16 * r + (15 - r), v);
    endtask

    task automatic clear_screen();
        int n;
        send_byte(8'h0C);
        wait_ready(n);
    endtask

    task automatic test_reset();
        int n;
        logic [7:0] v;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        x = 10'd0;
        y = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++;
            $display("FAIL rst_ready: got %b required 0", in_ready); end
        checks++; if (ascii_code !== 8'h20) begin errors++;
            $display("FAIL rst_ascii: got %h required 20", ascii_code); end
        checks++; if (cursor_col !== 5'd0 || cursor_row !== 2'd0) begin errors++;
            $display("FAIL rst_cursor: got (%0d,%0d) required (0,0)", cursor_row, cursor_col); end
        reset_n = 1'b1;
        wait_ready(n);
        checks++; if (n !== 128) begin errors++;
            $display("FAIL rst_clear_len: got %0d cycles required 128", n); end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                read_cell(r, c, v);
                checks++; if (v !== 8'h20) begin errors++;
                    $display("FAIL rst_cell(%0d,%0d): got %h required 20", r, c, v); end
            end
        end
    endtask

    task automatic test_print();
        logic [7:0] v;
        send_byte(8'h41);
        send_byte(8'hA1);
        checks++; if (cursor_row !== 2'd0 || cursor_col !== 5'd2) begin errors++;
            $display("FAIL print_cursor: got (%0d,%0d) required (0,2)", cursor_row, cursor_col); end
        read_xy(192, 208, v);
        checks++; if (v !== 8'h41) begin errors++;
            $display("FAIL print_cell0: got %h required 41", v); end
        // Registered output must not follow x until the next edge.
        x = 10'd200;
        #2;
        checks++; if (ascii_code !== 8'h41) begin errors++;
            $display("FAIL print_latency: got %h required 41", ascii_code); end
        @(posedge clk);
        #1;
        checks++; if (ascii_code !== 8'hA1) begin errors++;
            $display("FAIL print_cell1: got %h required A1", ascii_code); end
        read_xy(100, 208, v);
        checks++; if (v !== 8'h20) begin errors++;
            $display("FAIL print_left_out: got %h required 20", v); end
        read_xy(199, 223, v);
        checks++; if (v !== 8'h41) begin errors++;
            $display("FAIL print_cell0_corner: got %h required 41", v); end
        read_xy(192, 207, v);
        checks++; if (v !== 8'h20) begin errors++;
            $display("FAIL print_above_out: got %h required 20", v); end
    endtask

    task automatic test_controls();
        logic [7:0] v;
        send_byte(8'h01);
        send_byte(8'h7F);
        send_byte(8'h1F);
        checks++; if (cursor_row !== 2'd0 || cursor_col !== 5'd2) begin errors++;
            $display("FAIL ctrl_cursor: got (%0d,%0d) required (0,2)", cursor_row, cursor_col); end
        read_cell(0, 2, v);
        checks++; if (v !== 8'h20) begin errors++;
            $display("FAIL ctrl_cell2: got %h required 20", v); end
        read_cell(0, 1, v);
        checks++; if (v !== 8'hA1) begin errors++;
            $display("FAIL ctrl_cell1: got %h required A1", v); end
    endtask

    task automatic test_wrap_backspace();
        logic [7:0] v;
        clear_screen();
        send_byte(8'h08);
        checks++; if (cursor_row !== 2'd0 || cursor_col !== 5'd0) begin errors++;
            $display("FAIL bs_origin: got (%0d,%0d) required (0,0)", cursor_row, cursor_col); end
        for (int i = 0; i < 33; i++) send_byte(8'(8'h30 + i));
        checks++; if (cursor_row !== 2'd1 || cursor_col !== 5'd1) begin errors++;
            $display("FAIL wrap_cursor: got (%0d,%0d) required (1,1)", cursor_row, cursor_col); end
        read_xy(192, 224, v);
        checks++; if (v !== 8'h50) begin errors++;
            $display("FAIL wrap_byte33: got %h required 50", v); end
        read_xy(447, 208, v);
        checks++; if (v !== 8'h4F) begin errors++;
            $display("FAIL wrap_last_col: got %h required 4F", v); end
        read_xy(448, 208, v);
        checks++; if (v !== 8'h20) begin errors++;
            $display("FAIL wrap_right_out: got %h required 20", v); end
        read_xy(192, 272, v);
        checks++; if (v !== 8'h20) begin errors++;
            $display("FAIL wrap_below_out: got %h required 20", v); end
        read_cell(0, 5, v);
        checks++; if (v !== 8'h35) begin errors++;
            $display("FAIL wrap_cell5: got %h required 35", v); end
        send_byte(8'h08);
        send_byte(8'h08);
        checks++; if (cursor_row !== 2'd0 || cursor_col !== 5'd31) begin errors++;
            $display("FAIL bs_cursor: got (%0d,%0d) required (0,31)", cursor_row, cursor_col); end
        read_cell(0, 31, v);
        checks++; if (v !== 8'h20) begin errors++;
            $display("FAIL bs_cell_0_31: got %h required 20", v); end
        read_cell(1, 0, v);
        checks++; if (v !== 8'h20) begin errors++;
            $display("FAIL bs_cell_1_0: got %h required 20", v); end
        read_cell(0, 30, v);
        checks++; if (v !== 8'h4E) begin errors++;
            $display("FAIL bs_cell_0_30: got %h required 4E", v); end
    endtask

    task automatic test_last_row();
        int n;
        logic [7:0] v;
        logic [7:0] exp_rows [4];
        int exp_len;
        logic [1:0] exp_row;
`ifdef TEXT_SCROLL_EN
        exp_rows[0] = 8'h42; exp_rows[1] = 8'h43; exp_rows[2] = 8'h44; exp_rows[3] = 8'h20;
        exp_len = 128;
        exp_row = 2'd3;
`else
        exp_rows[0] = 8'h20; exp_rows[1] = 8'h42; exp_rows[2] = 8'h43; exp_rows[3] = 8'h44;
        exp_len = 32;
        exp_row = 2'd0;
`endif
        clear_screen();
        send_byte(8'h41); send_byte(8'h0D);
        send_byte(8'h42); send_byte(8'h0D);
        send_byte(8'h43); send_byte(8'h0D);
        send_byte(8'h44);
        checks++; if (cursor_row !== 2'd3 || cursor_col !== 5'd1) begin errors++;
            $display("FAIL lf_pre_cursor: got (%0d,%0d) required (3,1)", cursor_row, cursor_col); end
        send_byte(8'h0D);
        wait_ready(n);
        checks++; if (n !== exp_len) begin errors++;
            $display("FAIL lf_busy_len: got %0d cycles required %0d", n, exp_len); end
        for (int r = 0; r < ROWS; r++) begin
            read_cell(r, 0, v);
            checks++; if (v !== exp_rows[r]) begin errors++;
                $display("FAIL lf_row%0d: got %h required %h", r, v, exp_rows[r]); end
        end
        read_cell(1, 1, v);
        checks++; if (v !== 8'h20) begin errors++;
            $display("FAIL lf_row1_col1: got %h required 20", v); end
        checks++; if (cursor_row !== exp_row || cursor_col !== 5'd0) begin errors++;
            $display("FAIL lf_cursor: got (%0d,%0d) required (%0d,0)", cursor_row, cursor_col,
                     exp_row); end
    endtask

    task automatic test_ff_hold();
        int low;
        logic [7:0] v;
        clear_screen();
        send_byte(8'h5A);
        in_data  = 8'h0C;
        in_valid = 1'b1;
        low = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (in_ready) break;
            low++;
        end
        in_valid = 1'b0;
        checks++; if (low !== 128) begin errors++;
            $display("FAIL ff_busy_len: got %0d cycles required 128", low); end
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++;
            $display("FAIL ff_single_consume: in_ready got %b required 1", in_ready); end
        read_cell(0, 0, v);
        checks++; if (v !== 8'h20) begin errors++;
            $display("FAIL ff_cell0: got %h required 20", v); end
        checks++; if (cursor_row !== 2'd0 || cursor_col !== 5'd0) begin errors++;
            $display("FAIL ff_cursor: got (%0d,%0d) required (0,0)", cursor_row, cursor_col); end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        logic [7:0] v;
        send_byte(8'h5A);
        send_byte(8'h51);
        send_byte(8'h0C);
        repeat (49) begin
            @(posedge clk);
            #1;
        end
        checks++; if (in_ready !== 1'b0) begin errors++;
            $display("FAIL mid_busy: in_ready got %b required 0", in_ready); end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0 || ascii_code !== 8'h20) begin errors++;
            $display("FAIL mid_rst_out: ready %b ascii %h required 0 and 20", in_ready,
                     ascii_code); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_ready(n);
        checks++; if (n !== 128) begin errors++;
            $display("FAIL mid_restart_len: got %0d cycles required 128", n); end
        read_cell(0, 1, v);
        checks++; if (v !== 8'h20) begin errors++;
            $display("FAIL mid_cell1: got %h required 20", v); end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_print();
        test_controls();
        test_wrap_backspace();
        test_last_row();
        test_ff_hold();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_buffer.md
TEXT_BUFFER -- requirements
Module: text_buffer

Interface
REQ-001 Parameter X0, default 192, left pixel edge of the text window.
REQ-002 Parameter Y0, default 208, top pixel edge of the text window.
REQ-003 Parameter COLS, default 32, characters per row (8 px wide each).
REQ-004 Parameter ROWS, default 4, character rows (16 px tall each).
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 in_data  input  8  character or control byte from the keyboard/UART receiver; bit7=1 selects the Thai glyph set.
REQ-008 in_valid  input  1  in_data is valid.
REQ-009 in_ready  output  1  block can accept a byte this cycle.
REQ-010 x, y  input  10 each  current pixel position from the VGA sync generator.
REQ-011 ascii_code  output  8  code of the character cell under (x,y), fed to the glyph/colour stage.
REQ-012 cursor_col  output  5  current write column.
REQ-013 cursor_row  output  2  current write row.

Function
REQ-014 Storage SHALL be COLS*ROWS bytes, cell index = row*COLS+col.
REQ-015 Read path: col=(x-X0)>>3 and row=(y-Y0)>>4; ascii_code SHALL be registered with exactly 1-cycle latency from x,y.
REQ-016 Outside the window (x<X0, x>=X0+8*COLS, y<Y0, y>=Y0+16*ROWS), ascii_code SHALL be 8'h20.
REQ-017 A read and a write of the same cell in the same cycle SHALL return the old value.
REQ-018 A byte is accepted only when in_valid && in_ready; in_ready SHALL be high only in state IDLE.
REQ-019 States: IDLE, CLEAR, SCROLL; CLEAR and SCROLL write exactly one cell per cycle, then return to IDLE.
REQ-020 Printable (8'h20-8'h7E, 8'h80-8'hFF): write at cursor, col+1; at col=COLS-1, col<=0 with row advance.
REQ-021 8'h0D (CR): col<=0 with row advance.
REQ-022 8'h08 (BS): col>0 -> col-1 and write 8'h20 there; col=0,row>0 -> (row-1, COLS-1) written 8'h20; (0,0) -> no change.
REQ-023 8'h0C (FF): enter CLEAR for all COLS*ROWS cells (8'h20), then cursor <= (0,0).
REQ-024 All other bytes (8'h00-8'h1F except above, 8'h7F): accepted and discarded, no state change.
REQ-025 Row advance with row<ROWS-1: row+1, no stall.
REQ-026 Row advance at row=ROWS-1: behaviour per REQ-030/031; in_ready low for the whole operation.
REQ-027 Video reads SHALL continue during CLEAR/SCROLL; partially updated content is acceptable.

Reset
REQ-028 While reset_n=0: cursor (0,0), ascii_code 8'h20, in_ready 0, state forced to CLEAR at index 0.
REQ-029 After reset_n rises: full clear of COLS*ROWS cells (128 cycles at defaults), then IDLE with in_ready=1; reset asserted mid-CLEAR/SCROLL aborts and restarts the full clear.

Configuration
REQ-030 With TEXT_SCROLL_EN defined: SCROLL copies rows 1..ROWS-1 to rows 0..ROWS-2 (96 cycles), clears the last row (32 cycles), cursor <= (ROWS-1, 0).
REQ-031 Without TEXT_SCROLL_EN: cursor wraps to (0,0); row 0 is cleared (32 cycles, state CLEAR); no SCROLL state logic is synthesised.

Verification
REQ-032 Reset, then 128 clocks -> in_ready=1 exactly at cycle 129; every in-window cell reads 8'h20.
REQ-033 Send 8'h41, 8'hA1 -> cursor (0,2); x=192,y=208 -> ascii_code 8'h41 one cycle later; x=200 -> 8'hA1; x=100 -> 8'h20.
REQ-034 Send 33 printable bytes -> cursor (1,1); byte 33 visible at x=192,y=224; then 8'h08 x2 -> cursor (0,31), cell (0,31)=8'h20.
REQ-035 TEXT_SCROLL_EN: fill 4 rows with CR-terminated 'A','B','C','D' lines -> in_ready low 128 cycles; rows read B,C,D,blank; cursor (3,0).
REQ-036 Without TEXT_SCROLL_EN, same stimulus -> in_ready low 32 cycles; row 0 blank, rows 1-3 B,C,D; cursor (0,0).
REQ-037 8'h0C with in_valid held high -> exactly one byte consumed, in_ready low 128 cycles; reset_n pulsed low at cycle 50 -> clear restarts, in_ready high 128 cycles after release.
